// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package sub_pkg;

   // Controller states: waiting for a request, or shifting digits through.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Ceiling log2, used to size the digit counter. Returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
//
// Handshake: the master raises start with a, b, bin stable; the request is
// taken on the rising edge where start=1 and busy=0 (start while busy is
// ignored). busy stays high until the result edge, then done pulses for
// exactly one cycle. diff/br/ovf are valid from that edge and hold until the
// next operation completes. A new start may be presented in the done cycle.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             br;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, br, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, br, ovf
   );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// W-bit combinational full subtractor: {bo, d} = x - y - bi.
module full_subtractor #(
   parameter int W = 1
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         bi,
   output logic [W-1:0] d,
   output logic         bo
);

   logic [W:0] t;

   // One extra bit on top: it becomes 1 exactly when x < y + bi.
   assign t       = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
   assign {bo, d} = t;

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per
// clock, borrow carried between digits in a flop. Latency WIDTH/DIGIT cycles.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus,
   output state_t              state_dbg
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

   generate
      if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_sh, b_sh, diff_q;
   logic             borrow_q;
   logic             a_msb_q, b_msb_q;
   logic             done_q, br_q, ovf_q;

   logic             accept, last;
   logic [DIGIT-1:0] dig_d;
   logic             dig_bo;
   logic [WIDTH-1:0] diff_shift;

   full_subtractor #(.W(DIGIT)) u_fs (
      .x  (a_sh[DIGIT-1:0]),
      .y  (b_sh[DIGIT-1:0]),
      .bi (borrow_q),
      .d  (dig_d),
      .bo (dig_bo)
   );

   // New digits enter the result register from the MSB side, so after N
   // shifts the first (least significant) digit has reached bit 0.
   generate
      if (DIGIT == WIDTH) begin : g_single
         assign diff_shift = dig_d;
      end else begin : g_multi
         assign diff_shift = {dig_d, diff_q[WIDTH-1:DIGIT]};
      end
   endgenerate

   assign accept = (state_q == IDLE) && bus.start;
   assign last   = (state_q == RUN) && (cnt_q == CW'(N - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand capture, digit shifting, borrow chain and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         done_q   <= 1'b0;
         br_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            borrow_q <= bus.bin;
            cnt_q    <= '0;
            // Operand sign bits are shifted out during RUN; keep them for ovf.
            a_msb_q  <= bus.a[WIDTH-1];
            b_msb_q  <= bus.b[WIDTH-1];
         end else if (state_q == RUN) begin
            a_sh     <= a_sh >> DIGIT;
            b_sh     <= b_sh >> DIGIT;
            diff_q   <= diff_shift;
            borrow_q <= dig_bo;
            cnt_q    <= cnt_q + CW'(1);
            if (last) begin
               done_q <= 1'b1;
               br_q   <= dig_bo;
               ovf_q  <= (a_msb_q != b_msb_q) && (dig_d[DIGIT-1] != a_msb_q);
            end
         end
      end
   end

   assign bus.busy  = (state_q == RUN);
   assign bus.done  = done_q;
   assign bus.diff  = diff_q;
   assign bus.br    = br_q;
   assign bus.ovf   = ovf_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: DIGIT=1, 4 and 8 instances at
// WIDTH=8, directed steps plus random operands against a reference model.
module tb_serial_subtractor;
   import sub_pkg::*;

   logic   clk;
   logic   rst;
   int     cyc;
   int     tests;
   int     failed;
   state_t st1, st4, st8;

   serial_subtractor_if #(.WIDTH(8)) if1 ();
   serial_subtractor_if #(.WIDTH(8)) if4 ();
   serial_subtractor_if #(.WIDTH(8)) if8 ();

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .bus(if1.slave), .state_dbg(st1));
   serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .bus(if4.slave), .state_dbg(st4));
   serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst(rst), .bus(if8.slave), .state_dbg(st8));

   // Scoreboards: packed {diff, br, ovf} and the cycle the done pulse is due.
   logic [9:0] exp_q1[$], exp_q4[$], exp_q8[$];
   int         cyc_q1[$], cyc_q4[$], cyc_q8[$];

   // Clock and cycle counter.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int         d;
      logic [7:0] dd;
      logic       brw, ov;
      d   = int'(a) - int'(b) - int'(bin);
      dd  = d[7:0];
      brw = (d < 0);
      ov  = (a[7] != b[7]) && (dd[7] != a[7]);
      return {dd, brw, ov};
   endfunction

   // Monitors: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && if1.done) begin
         if (exp_q1.size() == 0) check("d1_spurious_done", 32'd1, 32'd0);
         else begin
            check("d1_result", {if1.diff, if1.br, if1.ovf}, exp_q1.pop_front());
            check("d1_latency", cyc, cyc_q1.pop_front());
         end
      end
      if (!rst && if4.done) begin
         if (exp_q4.size() == 0) check("d4_spurious_done", 32'd1, 32'd0);
         else begin
            check("d4_result", {if4.diff, if4.br, if4.ovf}, exp_q4.pop_front());
            check("d4_latency", cyc, cyc_q4.pop_front());
         end
      end
      if (!rst && if8.done) begin
         if (exp_q8.size() == 0) check("d8_spurious_done", 32'd1, 32'd0);
         else begin
            check("d8_result", {if8.diff, if8.br, if8.ovf}, exp_q8.pop_front());
            check("d8_latency", cyc, cyc_q8.pop_front());
         end
      end
   end

   // Driver for the DIGIT=1 instance; call at a negedge with the block able to accept.
   task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic [9:0] exp);
      if1.start = 1'b1;
      if1.a     = a;
      if1.b     = b;
      if1.bin   = bin;
      exp_q1.push_back(exp);
      cyc_q1.push_back(cyc + 1 + 8);
      @(negedge clk);
      if1.start = 1'b0;
      check("d1_busy_after_start", if1.busy, 1'b1);
   endtask

   // Driver for the DIGIT=4 and DIGIT=8 instances with shared operands.
   task automatic op_w(input logic [7:0] a, input logic [7:0] b, input logic bin);
      if4.start = 1'b1; if4.a = a; if4.b = b; if4.bin = bin;
      if8.start = 1'b1; if8.a = a; if8.b = b; if8.bin = bin;
      exp_q4.push_back(model(a, b, bin));
      exp_q8.push_back(model(a, b, bin));
      cyc_q4.push_back(cyc + 1 + 2);
      cyc_q8.push_back(cyc + 1 + 1);
      @(negedge clk);
      if4.start = 1'b0;
      if8.start = 1'b0;
      check("d4_busy_after_start", if4.busy, 1'b1);
      check("d8_busy_after_start", if8.busy, 1'b1);
   endtask

   // Wait (bounded) until every outstanding result has been seen.
   task automatic drain();
      int left;
      for (int i = 0; i < 200; i++) begin
         if (exp_q1.size() + exp_q4.size() + exp_q8.size() == 0) break;
         @(negedge clk);
         #1;
      end
      left = exp_q1.size() + exp_q4.size() + exp_q8.size();
      check("drain_timeout", left, 0);
      exp_q1.delete(); exp_q4.delete(); exp_q8.delete();
      cyc_q1.delete(); cyc_q4.delete(); cyc_q8.delete();
   endtask

   // Directed steps followed by random operands.
   initial begin
      logic [7:0] ra, rb;
      logic       rbin;
      bit         seen;
      tests = 0; failed = 0; cyc = 0;
      rst = 1'b1;
      if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
      if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
      if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state.
      check("rst_busy", if1.busy, 1'b0);
      check("rst_done", if1.done, 1'b0);
      check("rst_diff", if1.diff, 8'h00);
      check("rst_br",   if1.br,   1'b0);
      check("rst_ovf",  if1.ovf,  1'b0);
      check("rst_state", st1, IDLE);

      // Basic, borrowing and overflowing subtractions.
      op1(8'h05, 8'h03, 1'b0, {8'h02, 1'b0, 1'b0}); drain();
      op1(8'h03, 8'h05, 1'b0, {8'hFE, 1'b1, 1'b0}); drain();
      op1(8'h00, 8'h00, 1'b1, {8'hFF, 1'b1, 1'b0}); drain();
      op1(8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b1}); drain();
      op1(8'h7F, 8'hFF, 1'b0, {8'h80, 1'b1, 1'b1}); drain();
      check("hold_diff_idle", if1.diff, 8'h80);

      // Start re-pulsed mid-RUN is ignored; start in the done cycle is accepted.
      op1(8'h05, 8'h03, 1'b0, {8'h02, 1'b0, 1'b0});
      repeat (2) @(negedge clk);
      if1.start = 1'b1; if1.a = 8'hAA; if1.b = 8'h11; if1.bin = 1'b1;
      @(negedge clk);
      if1.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if1.done) begin
            seen = 1'b1;
            break;
         end
      end
      check("d1_done_seen", seen, 1'b1);
      check("d1_busy_in_done_cycle", if1.busy, 1'b0);
      op1(8'h03, 8'h05, 1'b0, {8'hFE, 1'b1, 1'b0});
      drain();

      // Reset in the middle of RUN abandons the operation.
      if1.start = 1'b1; if1.a = 8'h10; if1.b = 8'h01; if1.bin = 1'b0;
      @(negedge clk);
      if1.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", if1.busy, 1'b0);
      check("midrst_done", if1.done, 1'b0);
      check("midrst_diff", if1.diff, 8'h00);
      check("midrst_br",   if1.br,   1'b0);
      check("midrst_ovf",  if1.ovf,  1'b0);
      check("midrst_state", st1, IDLE);
      repeat (10) @(negedge clk);
      op1(8'h05, 8'h03, 1'b0, {8'h02, 1'b0, 1'b0}); drain();

      // Random operands on the bit-serial instance.
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         op1(ra, rb, rbin, model(ra, rb, rbin));
         drain();
      end

      // Wide-digit instances: corner operands, then random.
      op_w(8'h00, 8'h00, 1'b0); drain();
      op_w(8'h00, 8'h00, 1'b1); drain();
      op_w(8'hFF, 8'hFF, 1'b1); drain();
      op_w(8'h00, 8'hFF, 1'b1); drain();
      op_w(8'hFF, 8'h00, 1'b0); drain();
      op_w(8'h80, 8'h01, 1'b0); drain();
      op_w(8'h7F, 8'hFF, 1'b0); drain();
      op_w(8'h0F, 8'h0F, 1'b1); drain();
      for (int i = 0; i < 400; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         op_w(ra, rb, rbin);
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
